// File: rtl/stream_conv_relu_pkg.sv
// Shared types and arithmetic helpers for the streaming conv/ReLU stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: acc_t / px_t wide working types, out_size() and relu_sat().
package conv_pkg;

   localparam int ACC_MAX = 64;
   localparam int PX_MAX  = 32;

   // Wide enough for any legal ACC_SIZE / PX_SIZE; callers cast down to their own widths.
   typedef logic signed [ACC_MAX-1:0] acc_t;
   typedef logic        [PX_MAX-1:0]  px_t;

   // Side length of the valid-convolution output region.
   function automatic int out_size(input int img_size, input int k);
      return img_size - k + 1;
   endfunction

   // ReLU, arithmetic right shift, then clamp to an unsigned px_bits-wide value.
   function automatic px_t relu_sat(input acc_t acc, input int shift, input int px_bits);
      acc_t r;
      acc_t lim;
      if (acc < 0) r = '0;
      else         r = acc >>> shift;
      lim = (acc_t'(1) <<< px_bits) - acc_t'(1);
      if (r > lim) r = lim;
      return px_t'(r);
   endfunction

endpackage

// File: rtl/stream_conv_relu_if.sv
// Pixel-in / result-out valid-ready bundle for stream_conv_relu.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry standard valid-ready semantics.
// Modports: slave = the conv block, master = upstream source plus downstream sink.
interface stream_conv_relu_if
   import conv_pkg::*;
#(
   parameter int IN_CH   = 3,
   parameter int OUT_CH  = 6,
   parameter int PX_SIZE = 8
);

   logic                              in_valid;
   logic                              in_ready;
   logic [IN_CH-1:0][PX_SIZE-1:0]     in_px;
   logic                              out_valid;
   logic                              out_ready;
   logic [OUT_CH-1:0][PX_SIZE-1:0]    out_px;
   logic                              out_last;

   modport slave (
      input  in_valid, in_px, out_ready,
      output in_ready, out_valid, out_px, out_last
   );

   modport master (
      output in_valid, in_px, out_ready,
      input  in_ready, out_valid, out_px, out_last
   );

endinterface

// File: rtl/stream_conv_relu_line_buffer.sv
// Row delay lines plus sliding KxK window for raster-order pixel streams.
// Latency: window is combinational on the current pixel; storage updates on shift_en.
// Backpressure: none internally; holds state whenever shift_en is low.
// Ports: clk, shift_en (accept strobe), in_px (incoming pixel), window [ky][kx][ch][bit], tap [0][0] oldest.
module line_buffer
   import conv_pkg::*;
#(
   parameter int IMG_SIZE    = 32,
   parameter int IN_CH       = 3,
   parameter int KERNEL_SIZE = 3,
   parameter int PX_SIZE     = 8
)
(
   input  logic                                                             clk,
   input  logic                                                             shift_en,
   input  logic [IN_CH-1:0][PX_SIZE-1:0]                                    in_px,
   output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][IN_CH-1:0][PX_SIZE-1:0]  window
);

   typedef logic [IN_CH-1:0][PX_SIZE-1:0] pix_t;

   // rows[j] is a one-row delay chain; its oldest element is the pixel
   // (KERNEL_SIZE-1-j) rows above the incoming one, same column.
   pix_t rows [KERNEL_SIZE-1][IMG_SIZE];
   // Only the K-1 older window columns are stored; the newest column is the
   // live tail of each row chain, so the window already includes in_px on
   // the accepting edge and the result can be registered with one cycle latency.
   pix_t cols [KERNEL_SIZE][KERNEL_SIZE-1];
   // tail[ky] = pixel entering window row ky on the next shift.
   pix_t tail [KERNEL_SIZE];

   always_comb begin
      for (int j = 0; j < KERNEL_SIZE-1; j++) tail[j] = rows[j][IMG_SIZE-1];
      tail[KERNEL_SIZE-1] = in_px;

      window = '0;
      for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
         for (int kx = 0; kx < KERNEL_SIZE-1; kx++) window[ky][kx] = cols[ky][kx];
         window[ky][KERNEL_SIZE-1] = tail[ky];
      end
   end

   // Data storage carries no reset: contents before the first full window are never used.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int j = 0; j < KERNEL_SIZE-1; j++) begin
            rows[j][0] <= tail[j+1];
            for (int i = 1; i < IMG_SIZE; i++) rows[j][i] <= rows[j][i-1];
         end
         for (int ky = 0; ky < KERNEL_SIZE; ky++)
            for (int kx = 0; kx < KERNEL_SIZE-1; kx++)
               cols[ky][kx] <= window[ky][kx+1];
      end
   end

endmodule

// File: rtl/stream_conv_relu.sv
// Streaming valid-region KxK convolution with ReLU, shift and saturation.
// Latency: 1 cycle from the accept completing a window to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; output held while stalled.
// Ports: clk, rst (sync, active high), weights [o][ky][kx][ch] signed, strm (slave modport).
module stream_conv_relu
   import conv_pkg::*;
#(
   parameter int IMG_SIZE    = 32,
   parameter int IN_CH       = 3,
   parameter int OUT_CH      = 6,
   parameter int KERNEL_SIZE = 3,
   parameter int PX_SIZE     = 8,
   parameter int ACC_SIZE    = 24,
   parameter int SHIFT       = 0
)
(
   input  logic clk,
   input  logic rst,
   input  logic signed [OUT_CH-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][IN_CH-1:0][PX_SIZE-1:0] weights,
   stream_conv_relu_if.slave strm
);

   localparam int CW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam logic [CW-1:0] LAST_IDX      = CW'(IMG_SIZE-1);
   localparam logic [CW-1:0] FILL_LAST_ROW = CW'(KERNEL_SIZE-2);
   localparam logic [CW-1:0] FIRST_OUT_COL = CW'(KERNEL_SIZE-1);

   typedef logic signed [ACC_SIZE-1:0] acc_w_t;
   typedef enum logic {FILL, STREAM} state_t;

   state_t                         state;
   logic [CW-1:0]                  col;
   logic [CW-1:0]                  row;
   logic                           out_valid_q;
   logic                           out_last_q;
   logic [OUT_CH-1:0][PX_SIZE-1:0] out_px_q;
   logic [OUT_CH-1:0][PX_SIZE-1:0] res;
   logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][IN_CH-1:0][PX_SIZE-1:0] window;
   acc_w_t                         acc [OUT_CH];
   logic                           accept;
   logic                           xfer;
   logic                           produce;
   logic                           frame_end;

   assign strm.in_ready  = !rst && (!out_valid_q || strm.out_ready);
   assign strm.out_valid = out_valid_q;
   assign strm.out_px    = out_px_q;
   assign strm.out_last  = out_last_q;

   assign accept    = strm.in_valid && strm.in_ready;
   assign xfer      = out_valid_q && strm.out_ready;
   assign produce   = accept && (state == STREAM) && (col >= FIRST_OUT_COL);
   assign frame_end = (row == LAST_IDX) && (col == LAST_IDX);

   line_buffer #(
      .IMG_SIZE    (IMG_SIZE),
      .IN_CH       (IN_CH),
      .KERNEL_SIZE (KERNEL_SIZE),
      .PX_SIZE     (PX_SIZE)
   ) u_line_buffer (
      .clk      (clk),
      .shift_en (accept),
      .in_px    (strm.in_px),
      .window   (window)
   );

   // Pixels are unsigned: a zero MSB is prepended before the signed multiply.
   always_comb begin
      for (int o = 0; o < OUT_CH; o++) begin
         acc[o] = '0;
         for (int ky = 0; ky < KERNEL_SIZE; ky++)
            for (int kx = 0; kx < KERNEL_SIZE; kx++)
               for (int c = 0; c < IN_CH; c++)
                  acc[o] = acc[o]
                         + acc_w_t'($signed({1'b0, window[ky][kx][c]}))
                         * acc_w_t'($signed(weights[o][ky][kx][c]));
         res[o] = PX_SIZE'(relu_sat(acc_t'(acc[o]), SHIFT, PX_SIZE));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         col         <= '0;
         row         <= '0;
         out_valid_q <= 1'b0;
         out_px_q    <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            if (col == LAST_IDX) begin
               col <= '0;
               row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            case (state)
               FILL:    if (row == FILL_LAST_ROW && col == LAST_IDX) state <= STREAM;
               STREAM:  if (frame_end) state <= FILL;
               default: state <= FILL;
            endcase
         end
         // A producing accept can only happen when the register is empty or
         // draining this edge, so it simply overwrites.
         if (produce) begin
            out_valid_q <= 1'b1;
            out_px_q    <= res;
            out_last_q  <= frame_end;
         end else if (xfer) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_conv_relu.sv
module tb_stream_conv_relu;
   import conv_pkg::*;

   localparam int IMG  = 4;
   localparam int K    = 3;
   localparam int ODIM = out_size(IMG, K);
   localparam int NOUT = ODIM * ODIM;
   localparam int NPIX = IMG * IMG;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic       in_valid;
   logic [7:0] in_px;
   logic       out_ready;
   logic signed [1:0][K-1:0][K-1:0][0:0][7:0] w;

   stream_conv_relu_if #(.IN_CH(1), .OUT_CH(2), .PX_SIZE(8)) b0 ();
   stream_conv_relu_if #(.IN_CH(1), .OUT_CH(2), .PX_SIZE(8)) b1 ();

   assign b0.in_valid  = in_valid;
   assign b0.in_px     = in_px;
   assign b0.out_ready = out_ready;
   assign b1.in_valid  = in_valid;
   assign b1.in_px     = in_px;
   assign b1.out_ready = out_ready;

   stream_conv_relu #(.IMG_SIZE(IMG), .IN_CH(1), .OUT_CH(2), .KERNEL_SIZE(K),
                      .PX_SIZE(8), .ACC_SIZE(24), .SHIFT(0))
      dut0 (.clk(clk), .rst(rst), .weights(w), .strm(b0));

   stream_conv_relu #(.IMG_SIZE(IMG), .IN_CH(1), .OUT_CH(2), .KERNEL_SIZE(K),
                      .PX_SIZE(8), .ACC_SIZE(24), .SHIFT(12))
      dut12 (.clk(clk), .rst(rst), .weights(w), .strm(b1));

   int         stim_q[$];
   int         acc_cyc[$];
   int         first_vld_cyc;
   logic [7:0] g0[$], g1[$], h0[$], h1[$];
   logic       gl[$];
   logic [7:0] hp0[$];
   logic       hl[$], hr[$];

   task automatic set_w_const(input int v0, input int v1);
      for (int ky = 0; ky < K; ky++)
         for (int kx = 0; kx < K; kx++) begin
            w[0][ky][kx][0] = 8'(v0);
            w[1][ky][kx][0] = 8'(v1);
         end
   endtask

   // ch0 passes the centre tap through, ch1 sums with -1 everywhere.
   task automatic set_w_centre();
      set_w_const(0, -1);
      w[0][1][1][0] = 8'sd1;
   endtask

   task automatic push_frame(input bit rev);
      for (int i = 0; i < NPIX; i++) stim_q.push_back(rev ? (NPIX-1-i) : i);
   endtask

   // Feeds stim_q, collects output transfers from both DUTs, optionally stalls
   // the first output for 'hold' cycles, then idles a few cycles to catch extras.
   task automatic stream(input int n_exp, input bit rnd_vld, input int hold);
      int idx = 0;
      int budget = 0;
      int held = 0;
      int tail = 0;
      bit hold_now;
      g0.delete(); g1.delete(); h0.delete(); h1.delete(); gl.delete();
      hp0.delete(); hl.delete(); hr.delete(); acc_cyc.delete();
      first_vld_cyc = -1;
      while (budget < 1000) begin
         if (idx >= stim_q.size() && g0.size() >= n_exp) begin
            if (tail == 3) break;
            tail++;
         end
         @(negedge clk);
         hold_now = b0.out_valid && (held < hold);
         in_valid = (idx < stim_q.size()) && (!rnd_vld || ($urandom_range(0, 2) != 0));
         if (in_valid) in_px = 8'(stim_q[idx]);
         else          in_px = 8'h00;
         out_ready = !hold_now;
         #1;
         if (b0.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (hold_now) begin
            held++;
            hp0.push_back(b0.out_px[0]);
            hl.push_back(b0.out_last);
            hr.push_back(b0.in_ready);
         end
         if (in_valid && b0.in_ready) begin
            acc_cyc.push_back(cyc);
            idx++;
         end
         if (b0.out_valid && out_ready) begin
            g0.push_back(b0.out_px[0]);
            g1.push_back(b0.out_px[1]);
            gl.push_back(b0.out_last);
            h0.push_back(b1.out_px[0]);
            h1.push_back(b1.out_px[1]);
         end
         budget++;
      end
      checks++;
      if (budget >= 1000) begin
         errors++;
         $display("FAIL stream_timeout outputs=%0d need=%0d", g0.size(), n_exp);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      stim_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_px = '0; out_ready = 1'b1;
      set_w_const(1, 1);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", b0.in_ready); end
      checks++;
      if (b0.out_valid !== 1'b0 || b0.out_last !== 1'b0 || b0.out_px !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs vld=%b last=%b px=%h exp 0/0/0000", b0.out_valid, b0.out_last, b0.out_px);
      end
      rst = 1'b0;
   endtask

   task automatic test_all_ones();
      set_w_const(1, 1);
      for (int i = 0; i < NPIX; i++) stim_q.push_back(1);
      stream(NOUT, 1'b0, 0);
      checks++;
      if (g0.size() != NOUT) begin errors++; $display("FAIL ones_count got=%0d exp=%0d", g0.size(), NOUT); end
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (g0[i] !== 8'd9 || g1[i] !== 8'd9 || gl[i] !== (i == NOUT-1)) begin
            errors++;
            $display("FAIL ones_out[%0d] got=%0d,%0d last=%b exp=9,9 last=%b", i, g0[i], g1[i], gl[i], i == NOUT-1);
         end
      end
      checks++;
      if (acc_cyc.size() < 11 || first_vld_cyc !== acc_cyc[10] + 1) begin
         errors++;
         $display("FAIL ones_latency first_valid_cyc=%0d exp=%0d", first_vld_cyc, acc_cyc.size() > 10 ? acc_cyc[10] + 1 : -1);
      end
   endtask

   task automatic test_ramp_relu();
      int e0 [4];
      e0 = '{5, 6, 9, 10};
      set_w_centre();
      push_frame(1'b0);
      stream(NOUT, 1'b0, 0);
      checks++;
      if (g0.size() != NOUT) begin errors++; $display("FAIL ramp_count got=%0d exp=%0d", g0.size(), NOUT); end
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (g0[i] !== 8'(e0[i]) || g1[i] !== 8'd0) begin
            errors++;
            $display("FAIL ramp_out[%0d] got=%0d,%0d exp=%0d,0", i, g0[i], g1[i], e0[i]);
         end
      end
   endtask

   task automatic test_saturate();
      set_w_const(127, 127);
      for (int i = 0; i < NPIX; i++) stim_q.push_back(255);
      stream(NOUT, 1'b0, 0);
      checks++;
      if (g0.size() != NOUT) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", g0.size(), NOUT); end
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (g0[i] !== 8'd255 || g1[i] !== 8'd255) begin
            errors++;
            $display("FAIL sat_shift0[%0d] got=%0d,%0d exp=255,255", i, g0[i], g1[i]);
         end
         checks++;
         if (h0[i] !== 8'd71 || h1[i] !== 8'd71) begin
            errors++;
            $display("FAIL sat_shift12[%0d] got=%0d,%0d exp=71,71", i, h0[i], h1[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int e0 [4];
      e0 = '{5, 6, 9, 10};
      set_w_centre();
      push_frame(1'b0);
      stream(NOUT, 1'b0, 3);
      checks++;
      if (hp0.size() != 3) begin errors++; $display("FAIL bp_hold_cycles got=%0d exp=3", hp0.size()); end
      for (int i = 0; i < hp0.size(); i++) begin
         checks++;
         if (hp0[i] !== 8'd5 || hl[i] !== 1'b0 || hr[i] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall[%0d] px=%0d last=%b in_ready=%b exp 5/0/0", i, hp0[i], hl[i], hr[i]);
         end
      end
      checks++;
      if (g0.size() != NOUT) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", g0.size(), NOUT); end
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (g0[i] !== 8'(e0[i]) || gl[i] !== (i == NOUT-1)) begin
            errors++;
            $display("FAIL bp_out[%0d] got=%0d last=%b exp=%0d", i, g0[i], gl[i], e0[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int e0 [8];
      e0 = '{5, 6, 9, 10, 10, 9, 6, 5};
      set_w_centre();
      push_frame(1'b0);
      push_frame(1'b1);
      stream(2*NOUT, 1'b0, 0);
      checks++;
      if (g0.size() != 2*NOUT) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", g0.size(), 2*NOUT); end
      checks++;
      if (acc_cyc.size() != 2*NPIX || acc_cyc[2*NPIX-1] - acc_cyc[0] != 2*NPIX-1) begin
         errors++;
         $display("FAIL b2b_gapless accepts=%0d exp=%0d", acc_cyc.size(), 2*NPIX);
      end
      for (int i = 0; i < 2*NOUT; i++) begin
         checks++;
         if (g0[i] !== 8'(e0[i]) || g1[i] !== 8'd0 || gl[i] !== (i == NOUT-1 || i == 2*NOUT-1)) begin
            errors++;
            $display("FAIL b2b_out[%0d] got=%0d,%0d last=%b exp=%0d,0", i, g0[i], g1[i], gl[i], e0[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int e0 [4];
      e0 = '{5, 6, 9, 10};
      set_w_centre();
      for (int i = 0; i < 7; i++) stim_q.push_back(200);
      stream(0, 1'b0, 0);
      rst = 1'b1;
      #1;
      checks++;
      if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready got=%b exp=0", b0.in_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (b0.out_valid !== 1'b0 || b0.out_px !== 16'h0 || b0.out_last !== 1'b0) begin
         errors++;
         $display("FAIL mrst_outputs vld=%b px=%h last=%b exp 0/0000/0", b0.out_valid, b0.out_px, b0.out_last);
      end
      push_frame(1'b0);
      stream(NOUT, 1'b1, 0);
      checks++;
      if (g0.size() != NOUT) begin errors++; $display("FAIL mrst_count got=%0d exp=%0d", g0.size(), NOUT); end
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (g0[i] !== 8'(e0[i]) || g1[i] !== 8'd0 || gl[i] !== (i == NOUT-1)) begin
            errors++;
            $display("FAIL mrst_out[%0d] got=%0d,%0d last=%b exp=%0d,0", i, g0[i], g1[i], gl[i], e0[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_ramp_relu();
      test_saturate();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
